// File: rtl/mmio_timer_responder.sv
// Memory-mapped prescaled timer responder for the CPU Dw* data bus (32-byte register window).
// Define TIMER_CAPTURE_EN to add the synchronised iCapture input and the CAPTURE register.

module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFF200500,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic        oHit,
`ifdef TIMER_CAPTURE_EN
  input  logic        iCapture,
`endif
  output logic        oIRQ
);

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_PRESC   = 3'd1,
    REG_COMPARE = 3'd2,
    REG_COUNT   = 3'd3,
    REG_STATUS  = 3'd4,
    REG_CAPTURE = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_e;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  localparam logic [PRESC_W-1:0] PSC_ONE = PRESC_W'(1);

  ctrl_t               ctrl;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  psc_cnt;
  logic [31:0]         compare;
  logic [31:0]         count;
  logic                match_flag;
  logic                ovf_flag;
  logic                capt_flag;
  logic [31:0]         capture_reg;

  reg_e        reg_sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        wr_compare;
  logic        wr_count;
  logic [31:0] be_mask;
  logic [31:0] reg_val;
  logic [31:0] wr_val;
  logic [2:0]  w1c_bits;
  logic        tick;
  logic        set_match;
  logic        set_ovf;
  logic [31:0] count_tick;

  // Address bits [1:0] only pick a byte inside a word; lane selection comes from DwByteEnable.
  logic unused_addr_bits;
  assign unused_addr_bits = ^DwAddress[1:0];

  assign oHit     = (DwAddress[31:5] == BASE_ADDR[31:5]);
  assign reg_sel  = reg_e'(DwAddress[4:2]);
  assign wr       = oHit & DwWriteEnable;
  assign wr_ctrl    = wr && (reg_sel == REG_CTRL);
  assign wr_presc   = wr && (reg_sel == REG_PRESC);
  assign wr_compare = wr && (reg_sel == REG_COMPARE);
  assign wr_count   = wr && (reg_sel == REG_COUNT);
  assign be_mask  = {{8{DwByteEnable[3]}}, {8{DwByteEnable[2]}},
                     {8{DwByteEnable[1]}}, {8{DwByteEnable[0]}}};

  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely combinational (no latch).
    reg_val = '0;
    case (reg_sel)
      REG_CTRL:    reg_val = {29'd0, ctrl};
      REG_PRESC:   reg_val = 32'(presc);
      REG_COMPARE: reg_val = compare;
      REG_COUNT:   reg_val = count;
      REG_STATUS:  reg_val = {29'd0, capt_flag, ovf_flag, match_flag};
      REG_CAPTURE: reg_val = capture_reg;
      default:     reg_val = '0;
    endcase
  end

  assign DwReadData = (oHit && DwReadEnable) ? reg_val : '0;

  // Lane-merged write value: unselected byte lanes keep the register's current contents.
  assign wr_val   = (reg_val & ~be_mask) | (DwWriteData & be_mask);
  assign w1c_bits = (wr && (reg_sel == REG_STATUS)) ? (DwWriteData[2:0] & be_mask[2:0]) : 3'b000;

  assign tick = ctrl.en && (psc_cnt == '0);

  always_comb begin
    count_tick = count;
    set_match  = 1'b0;
    set_ovf    = 1'b0;
    if (tick) begin
      if (count == compare) begin
        set_match  = 1'b1;
        count_tick = ctrl.auto_reload ? 32'd0 : count + 32'd1;
      end else if (count == 32'hFFFF_FFFF) begin
        set_ovf    = 1'b1;
        count_tick = 32'd0;
      end else begin
        count_tick = count + 32'd1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      ctrl       <= '0;
      presc      <= '0;
      psc_cnt    <= '0;
      compare    <= '0;
      count      <= '0;
      match_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_t'(wr_val[2:0]);

      if (wr_presc) begin
        presc   <= wr_val[PRESC_W-1:0];
        psc_cnt <= wr_val[PRESC_W-1:0];
      end else if (ctrl.en) begin
        psc_cnt <= tick ? presc : psc_cnt - PSC_ONE;
      end

      if (wr_compare) compare <= wr_val;

      // A CPU write to COUNT wins over the tick increment in the same cycle.
      count <= wr_count ? wr_val : count_tick;

      // Hardware set takes priority over a coincident write-1-to-clear.
      match_flag <= set_match | (match_flag & ~w1c_bits[0]);
      ovf_flag   <= set_ovf   | (ovf_flag   & ~w1c_bits[1]);
    end
  end

`ifdef TIMER_CAPTURE_EN
  // [1:0] is the two-flop synchroniser, [2] holds the previous synchronised level for edge detect.
  logic [2:0] capt_sync;
  logic       capt_edge;

  assign capt_edge = capt_sync[1] & ~capt_sync[2];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      capt_sync   <= '0;
      capture_reg <= '0;
      capt_flag   <= 1'b0;
    end else begin
      capt_sync <= {capt_sync[1:0], iCapture};
      if (capt_edge) capture_reg <= count;
      capt_flag <= capt_edge | (capt_flag & ~w1c_bits[2]);
    end
  end
`else
  logic unused_capt_clear;
  assign unused_capt_clear = w1c_bits[2];
  assign capt_flag         = 1'b0;
  assign capture_reg       = '0;
`endif

  assign oIRQ = ctrl.irq_en & (match_flag | ovf_flag);

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: directed literal cases plus randomized bus traffic
// compared every cycle against a register-level reference model.

module tb_mmio_timer_responder;

  localparam logic [31:0] BASE = 32'hFF200500;
  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_PRESC   = 32'h04;
  localparam logic [31:0] OFF_COMPARE = 32'h08;
  localparam logic [31:0] OFF_COUNT   = 32'h0C;
  localparam logic [31:0] OFF_STATUS  = 32'h10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        re    = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wd    = 32'h0;
  logic [31:0] rd;
  logic        hit;
  logic        irq;
`ifdef TIMER_CAPTURE_EN
  logic        capture = 1'b0;
`endif

  always #5 clk = ~clk;

  mmio_timer_responder #(
    .BASE_ADDR (BASE),
    .PRESC_W   (16)
  ) dut (
    .iCLK          (clk),
    .iRST          (rst_n),
    .DwReadEnable  (re),
    .DwWriteEnable (we),
    .DwByteEnable  (be),
    .DwAddress     (addr),
    .DwWriteData   (wd),
    .DwReadData    (rd),
    .oHit          (hit),
`ifdef TIMER_CAPTURE_EN
    .iCapture      (capture),
`endif
    .oIRQ          (irq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as the programmer sees them.
  bit [2:0]  m_ctrl;
  bit [15:0] m_presc;
  bit [15:0] m_psc;
  bit [31:0] m_cmp;
  bit [31:0] m_cnt;
  bit        m_match;
  bit        m_ovf;

  function automatic bit in_window(input bit [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'h1F);
  endfunction

  function automatic bit [31:0] model_reg(input bit [31:0] a);
    int idx;
    idx = int'((a - BASE) >> 2);
    case (idx)
      0:       return {29'b0, m_ctrl};
      1:       return {16'b0, m_presc};
      2:       return m_cmp;
      3:       return m_cnt;
      4:       return {30'b0, m_ovf, m_match};
      default: return 32'b0;
    endcase
  endfunction

  function automatic bit [31:0] lane_merge(input bit [31:0] old, input bit [31:0] data, input bit [3:0] lanes);
    bit [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_presc = 0; m_psc = 0; m_cmp = 0; m_cnt = 0; m_match = 0; m_ovf = 0;
  endtask

  // Advance the model across one rising edge using the bus inputs currently applied.
  task automatic model_step();
    bit        tick;
    bit [15:0] psc_n;
    bit [31:0] cnt_n;
    bit        mset, oset, clr_m, clr_o;
    bit [31:0] nv;
    int        idx;
    tick  = m_ctrl[0] && (m_psc == 0);
    psc_n = m_psc;
    if (m_ctrl[0]) psc_n = tick ? m_presc : m_psc - 16'd1;
    cnt_n = m_cnt;
    mset = 0; oset = 0; clr_m = 0; clr_o = 0;
    if (tick) begin
      if (m_cnt == m_cmp) begin
        mset  = 1;
        cnt_n = m_ctrl[1] ? 32'd0 : m_cnt + 32'd1;
      end else if (m_cnt == 32'hFFFF_FFFF) begin
        oset  = 1;
        cnt_n = 32'd0;
      end else begin
        cnt_n = m_cnt + 32'd1;
      end
    end
    if (we && in_window(addr)) begin
      idx = int'((addr - BASE) >> 2);
      nv  = lane_merge(model_reg(addr), wd, be);
      case (idx)
        0: m_ctrl = nv[2:0];
        1: begin m_presc = nv[15:0]; psc_n = nv[15:0]; end
        2: m_cmp = nv;
        3: cnt_n = nv;
        4: begin clr_m = wd[0] & be[0]; clr_o = wd[1] & be[0]; end
        default: ;
      endcase
    end
    m_psc   = psc_n;
    m_cnt   = cnt_n;
    m_match = mset | (m_match & !clr_m);
    m_ovf   = oset | (m_ovf & !clr_o);
  endtask

  // Compare process: every falling edge the outputs must equal the model's view.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("hit",   32'(hit), 32'(in_window(addr)));
      check("rdata", rd, (re && in_window(addr)) ? model_reg(addr) : 32'h0);
      check("irq",   32'(irq), 32'(m_ctrl[2] & (m_match | m_ovf)));
      if (rst_n) model_step();
    end
  end

  // Stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data, input logic [3:0] lanes = 4'hF);
    addr = BASE + off; wd = data; be = lanes; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'h0; wd = 32'h0; addr = 32'h0;
  endtask

  task automatic peek(input logic [31:0] off, output logic [31:0] val, output logic h);
    addr = BASE + off; re = 1'b1;
    #1;
    val = rd; h = hit;
    re = 1'b0; addr = 32'h0;
  endtask

  logic [31:0] v;
  logic        h;

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    peek(OFF_COUNT, v, h);   check("reset_count", v, 32'h0);
    peek(OFF_CTRL, v, h);    check("reset_ctrl", v, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    step(1);

    wr_reg(OFF_COMPARE, 32'hAABBCCDD);
    wr_reg(OFF_COMPARE, 32'h11223344, 4'b0101);
    peek(OFF_COMPARE, v, h); check("byte_lanes", v, 32'hAA22CC44);
    wr_reg(OFF_PRESC, 32'hFFFF_0003);
    peek(OFF_PRESC, v, h);   check("presc_upper_dropped", v, 32'h3);

    wr_reg(OFF_COMPARE, 32'd5);
    wr_reg(OFF_CTRL, 32'h7);
    step(23);
    peek(OFF_COUNT, v, h);   check("count_before_match", v, 32'd5);
    check("irq_before_match", 32'(irq), 32'h0);
    step(1);
    peek(OFF_COUNT, v, h);   check("count_after_match", v, 32'd0);
    peek(OFF_STATUS, v, h);  check("match_flag", v, 32'h1);
    check("irq_after_match", 32'(irq), 32'h1);
    wr_reg(OFF_CTRL, 32'h0);
    wr_reg(OFF_STATUS, 32'h7);

    wr_reg(OFF_PRESC, 32'h0);
    wr_reg(OFF_COUNT, 32'hFFFF_FFFF);
    wr_reg(OFF_CTRL, 32'h1);
    peek(OFF_COUNT, v, h);   check("count_max", v, 32'hFFFF_FFFF);
    step(1);
    peek(OFF_COUNT, v, h);   check("count_wrap", v, 32'h0);
    peek(OFF_STATUS, v, h);  check("ovf_set", v, 32'h2);
    wr_reg(OFF_STATUS, 32'h2);
    peek(OFF_STATUS, v, h);  check("ovf_w1c", v, 32'h0);
    wr_reg(OFF_CTRL, 32'h0);
    wr_reg(OFF_COUNT, 32'hFFFF_FFFF);
    wr_reg(OFF_CTRL, 32'h1);
    wr_reg(OFF_STATUS, 32'h2);
    peek(OFF_STATUS, v, h);  check("ovf_set_beats_w1c", v, 32'h2);

    wr_reg(OFF_COUNT, 32'd100);
    peek(OFF_COUNT, v, h);   check("count_write_wins", v, 32'd100);
    step(1);
    peek(OFF_COUNT, v, h);   check("count_after_write", v, 32'd101);

    wr_reg(OFF_CTRL, 32'h5);
    check("irq_ovf_enabled", 32'(irq), 32'h1);
    wr_reg(32'h20, 32'h0);
    peek(32'h20, v, h);
    check("decode_hit", 32'(h), 32'h0);
    check("decode_rdata", v, 32'h0);
    peek(OFF_CTRL, v, h);    check("decode_no_write", v, 32'h5);

    rst_n = 1'b0;
    #1;
    check("midreset_irq", 32'(irq), 32'h0);
    peek(OFF_COUNT, v, h);   check("midreset_count", v, 32'h0);
    peek(OFF_STATUS, v, h);  check("midreset_status", v, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      int unsigned r;
      logic [31:0] off;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 2));
        rst_n = 1'b1;
      end else begin
        off = 32'($urandom_range(0, 7)) << 2;
        if ($urandom_range(0, 15) == 0)
          addr = ($urandom_range(0, 1) == 0) ? $urandom : BASE + 32'h20 + 32'($urandom_range(0, 31));
        else
          addr = BASE + off + 32'($urandom_range(0, 3));
        we = ($urandom_range(0, 3) == 0);
        re = $urandom_range(0, 1) == 1;
        be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        case (off)
          OFF_PRESC:   wd = 32'($urandom_range(0, 3));
          OFF_COMPARE: wd = 32'($urandom_range(0, 23));
          OFF_COUNT:   wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 23));
          default:     wd = $urandom;
        endcase
        step(1);
      end
    end
    we = 1'b0; re = 1'b0; be = 4'h0; addr = 32'h0; wd = 32'h0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
